// File: rtl/led_pkg.sv
// Shared constants for the LED PWM display path.
package led_pkg;
  localparam int N_LED_DEF    = 8;
  localparam int PWM_BITS_DEF = 4;
  localparam int FADE_DIV_DEF = 2;
  localparam int PWM_MAX      = (1 << PWM_BITS_DEF) - 1;
endpackage

// File: rtl/sync2.sv
// Parameterized-width two-flop synchronizer, async active-high reset to 0.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/led_pwm_driver.sv
// Per-LED PWM brightness with optional afterglow fade; pattern and brightness
// changes are applied only on PWM period boundaries so the pins never glitch.
module led_pwm_driver
  import led_pkg::*;
#(
  parameter int N_LED    = N_LED_DEF,
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int FADE_DIV = FADE_DIV_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_LED-1:0]    pattern_in,
  input  logic [PWM_BITS-1:0] bright,
  input  logic                fade_en,
  output logic [N_LED-1:0]    led_out,
  output logic                period_start
);
  localparam int FW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

  logic [N_LED-1:0]    pat_s;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [FW-1:0]       fade_cnt_q, fade_cnt_d;
  logic [PWM_BITS-1:0] level_q [N_LED];
  logic [PWM_BITS-1:0] level_d [N_LED];
  logic [N_LED-1:0]    led_q, led_d;
  logic                period_start_q;
  logic                boundary;
  logic                fade_step;

  sync2 #(.W(N_LED)) u_pat_sync (
    .clk (clk),
    .rst (reset),
    .d_i (pattern_in),
    .q_o (pat_s)
  );

  assign boundary  = (pwm_cnt_q == {PWM_BITS{1'b1}});
  assign fade_step = boundary && (fade_cnt_q == FW'(FADE_DIV - 1));

  always_comb begin
    pwm_cnt_d  = pwm_cnt_q + 1'b1;
    fade_cnt_d = fade_cnt_q;
    if (boundary) begin
      fade_cnt_d = (fade_cnt_q == FW'(FADE_DIV - 1)) ? '0 : fade_cnt_q + 1'b1;
    end
    for (int i = 0; i < N_LED; i++) begin
      level_d[i] = level_q[i];
      // A lit bit reloads bright even when a fade step coincides.
      if (boundary) begin
        if (pat_s[i]) begin
          level_d[i] = bright;
        end else if (!fade_en) begin
          level_d[i] = '0;
        end else if (fade_step && (level_q[i] != '0)) begin
          level_d[i] = level_q[i] - 1'b1;
        end
      end
      led_d[i] = (pwm_cnt_q < level_q[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt_q      <= '0;
      fade_cnt_q     <= '0;
      led_q          <= '0;
      period_start_q <= 1'b0;
      for (int i = 0; i < N_LED; i++) begin
        level_q[i] <= '0;
      end
    end else begin
      pwm_cnt_q      <= pwm_cnt_d;
      fade_cnt_q     <= fade_cnt_d;
      led_q          <= led_d;
      period_start_q <= (pwm_cnt_q == '0);
      for (int i = 0; i < N_LED; i++) begin
        level_q[i] <= level_d[i];
      end
    end
  end

  assign led_out      = led_q;
  assign period_start = period_start_q;
endmodule

// File: tb/tb_led_pwm_driver.sv
// Self-checking bench for led_pwm_driver: per-slot scoreboard of {period_start, led_out}.
module tb_led_pwm_driver;
  localparam int SLOTS = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pattern_in = 8'h00;
  logic [3:0] bright = 4'd0;
  logic       fade_en = 1'b0;
  logic [7:0] led_out;
  logic       period_start;

  logic [8:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  led_pwm_driver dut (
    .clk          (clk),
    .reset        (reset),
    .pattern_in   (pattern_in),
    .bright       (bright),
    .fade_en      (fade_en),
    .led_out      (led_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0][3:0] lv_from(input logic [7:0] pat, input logic [3:0] b);
    logic [7:0][3:0] lv;
    for (int i = 0; i < 8; i++) lv[i] = pat[i] ? b : 4'd0;
    return lv;
  endfunction

  function automatic logic [7:0] slot_vec(input logic [7:0][3:0] lv, input int s);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = (s < int'(lv[i]));
    return v;
  endfunction

  task automatic wait_ps(input string name);
    int k = 0;
    while (period_start !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (period_start !== 1'b1) begin
      $display("FAIL %s: period_start timeout, got %b want 1", name, period_start);
      n_fail++;
    end
  endtask

  // Slots are compared at consecutive negedges, the first at the current one.
  task automatic check_slots(input logic [7:0][3:0] lv, input int first, input int last,
                             input string name);
    logic [8:0] got, exp;
    for (int s = first; s <= last; s++)
      exp_q.push_back({((s % SLOTS) == 0), slot_vec(lv, s % SLOTS)});
    for (int s = first; s <= last; s++) begin
      if (s != first) @(negedge clk);
      got = {period_start, led_out};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
        $display("FAIL %s slot %0d: {period_start,led_out} got %h want %h", name, s, got, exp);
        n_fail++;
      end
    end
  endtask

  task automatic settle(input logic [7:0] pat, input logic [3:0] b, input logic fe,
                        input string name);
    pattern_in = pat;
    bright     = b;
    fade_en    = fe;
    repeat (3) @(negedge clk);
    wait_ps(name);
  endtask

  task automatic check_idle(input string name);
    n_checks++;
    if (led_out !== 8'h00 || period_start !== 1'b0) begin
      $display("FAIL %s: led_out=%h period_start=%b want 00/0", name, led_out, period_start);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pattern_in = 8'h00;
    repeat (3) @(negedge clk);
    check_idle("reset_hold");
    reset = 1'b0;
    @(negedge clk);
    check_slots(lv_from(8'h00, 4'd0), 0, 3 * SLOTS - 1, "reset_periodic");
  endtask

  task automatic test_single_led();
    settle(8'h01, 4'd8, 1'b0, "single_sync");
    check_slots(lv_from(8'h01, 4'd8), 0, SLOTS - 1, "single_led");
  endtask

  task automatic test_extremes();
    settle(8'hFF, 4'd0, 1'b0, "bright0_sync");
    check_slots(lv_from(8'hFF, 4'd0), 0, SLOTS - 1, "bright0");
    settle(8'hFF, 4'd15, 1'b0, "bright15_sync");
    check_slots(lv_from(8'hFF, 4'd15), 0, SLOTS - 1, "bright15");
  endtask

  task automatic test_random_patterns();
    logic [7:0] pat;
    logic [3:0] b;
    for (int n = 0; n < 4; n++) begin
      pat = 8'($urandom_range(0, 255));
      b   = 4'($urandom_range(0, 15));
      settle(pat, b, 1'b0, "random_sync");
      check_slots(lv_from(pat, b), 0, SLOTS - 1, "random");
    end
  endtask

  task automatic test_mid_period();
    settle(8'h0F, 4'd4, 1'b0, "mid_sync");
    check_slots(lv_from(8'h0F, 4'd4), 0, 4, "mid_old_head");
    pattern_in = 8'hF0;
    bright     = 4'd12;
    @(negedge clk);
    check_slots(lv_from(8'h0F, 4'd4), 5, SLOTS - 1, "mid_old_tail");
    @(negedge clk);
    check_slots(lv_from(8'hF0, 4'd12), 0, SLOTS - 1, "mid_new");
  endtask

  task automatic test_fade();
    int cnt7[32];
    int exp_c;
    settle(8'h80, 4'd15, 1'b0, "fade_setup_sync");
    check_slots(lv_from(8'h80, 4'd15), 0, SLOTS - 1, "fade_setup");
    settle(8'h40, 4'd15, 1'b1, "fade_sync");
    for (int p = 0; p < 32; p++) begin
      cnt7[p] = 0;
      for (int s = 0; s < SLOTS; s++) begin
        if (p != 0 || s != 0) @(negedge clk);
        cnt7[p] += int'(led_out[7]);
        n_checks++;
        if (led_out[6] !== (s < 15) || led_out[5:0] !== 6'h00 || period_start !== (s == 0)) begin
          $display("FAIL fade_others p%0d s%0d: led_out=%h ps=%b", p, s, led_out, period_start);
          n_fail++;
        end
      end
    end
    n_checks++;
    if (cnt7[0] != 15 && cnt7[0] != 14) begin
      $display("FAIL fade_first: bit7 count got %0d want 14 or 15", cnt7[0]);
      n_fail++;
    end
    for (int p = 1; p < 32; p++) begin
      n_checks++;
      if (cnt7[p] > cnt7[p-1] || cnt7[p-1] - cnt7[p] > 1) begin
        $display("FAIL fade_step p%0d: bit7 count got %0d after %0d", p, cnt7[p], cnt7[p-1]);
        n_fail++;
      end
    end
    for (int p = 2; p < 32; p++) begin
      exp_c = (cnt7[p-2] > 0) ? cnt7[p-2] - 1 : 0;
      n_checks++;
      if (cnt7[p] != exp_c) begin
        $display("FAIL fade_rate p%0d: bit7 count got %0d want %0d", p, cnt7[p], exp_c);
        n_fail++;
      end
    end
    n_checks++;
    if (cnt7[29] != 0) begin
      $display("FAIL fade_done: bit7 count at period 29 got %0d want 0", cnt7[29]);
      n_fail++;
    end
    settle(8'h80, 4'd15, 1'b0, "nofade_setup_sync");
    check_slots(lv_from(8'h80, 4'd15), 0, SLOTS - 1, "nofade_setup");
    settle(8'h00, 4'd15, 1'b0, "nofade_sync");
    check_slots(lv_from(8'h00, 4'd0), 0, SLOTS - 1, "nofade_dark");
  endtask

  task automatic test_reset_mid();
    settle(8'hFF, 4'd8, 1'b0, "rmid_sync");
    check_slots(lv_from(8'hFF, 4'd8), 0, 2, "rmid_pre");
    reset = 1'b1;
    #1;
    check_idle("rmid_async");
    pattern_in = 8'h00;
    repeat (3) @(negedge clk);
    check_idle("rmid_hold");
    reset = 1'b0;
    @(negedge clk);
    check_slots(lv_from(8'h00, 4'd0), 0, 2 * SLOTS - 1, "rmid_after");
  endtask

  initial begin
    test_reset();
    test_single_led();
    test_extremes();
    test_random_patterns();
    test_mid_period();
    test_fade();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
